// File: rtl/time_set_ctrl.sv
// time_set_ctrl: time-set controller for the 24 h digital clock datapath.
// Debounces the mode/inc push-buttons, runs the set-mode FSM
// (RUN -> SET_HR -> SET_MIN -> COMMIT), and drives the per-field blanking
// used to blink the field being edited.
// Optional feature: define TIMEOUT_EN to abandon an idle set session after
// TIMEOUT_CYC cycles without a press. Without it a session persists forever.
module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned BLINK_CYC    = 12500000,
  parameter int unsigned TIMEOUT_CYC  = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hr,
  input  logic [5:0] cur_min,
  output logic [4:0] set_hr,
  output logic [5:0] set_min,
  output logic       load,
  output logic       run_en,
  output logic       blank_hr,
  output logic       blank_min,
  output logic [1:0] mode
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  // Button index 0 = mode, 1 = inc.
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    db_q, db_d;
  logic [1:0]    press_q, press_d;
  logic [DW-1:0] db_cnt_q [2];
  logic [DW-1:0] db_cnt_d [2];

  state_t        state_q, state_d;
  logic [4:0]    set_hr_q, set_hr_d;
  logic [5:0]    set_min_q, set_min_d;
  logic          load_q, load_d;
  logic          run_en_q, run_en_d;
  logic          blank_hr_q, blank_hr_d;
  logic          blank_min_q, blank_min_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  logic mode_p, inc_p, in_set_d, entering;

  assign raw    = {btn_inc, btn_mode};
  assign mode_p = press_q[0];
  assign inc_p  = press_q[1];

  // Synchronize, debounce and edge-detect both buttons.
  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    sync1_d = raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    for (int k = 0; k < 2; k++) begin
      db_cnt_d[k] = '0;
      if (sync2_q[k] != db_q[k]) begin
        if (db_cnt_q[k] == DW'(DEBOUNCE_CYC - 1)) begin
          db_d[k] = sync2_q[k];
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DW'(1);
        end
      end
    end
    press_d = db_d & ~db_q;
  end

`ifdef TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] idle_q, idle_d;
  logic          timed_out;
  assign timed_out = ((state_q == SET_HR) || (state_q == SET_MIN)) &&
                     !mode_p && !inc_p && (idle_q == TW'(TIMEOUT_CYC - 1));
`else
  logic timed_out;
  assign timed_out = 1'b0;
`endif

  // Next-state, edited values, blink timing and registered outputs.
  always_comb begin
    state_d   = state_q;
    set_hr_d  = set_hr_q;
    set_min_d = set_min_q;
    unique case (state_q)
      RUN: begin
        if (mode_p) begin
          state_d   = SET_HR;
          set_hr_d  = cur_hr;
          set_min_d = cur_min;
        end
      end
      SET_HR: begin
        if (mode_p) begin
          state_d = SET_MIN;
        end else if (inc_p) begin
          set_hr_d = (set_hr_q == 5'd23) ? 5'd0 : set_hr_q + 5'd1;
        end
      end
      SET_MIN: begin
        if (mode_p) begin
          state_d = COMMIT;
        end else if (inc_p) begin
          set_min_d = (set_min_q == 6'd59) ? 6'd0 : set_min_q + 6'd1;
        end
      end
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase
    if (timed_out) begin
      state_d = RUN;
    end

    in_set_d = (state_d == SET_HR) || (state_d == SET_MIN);
    entering = in_set_d && (state_d != state_q);

    blink_cnt_d = '0;
    phase_d     = 1'b0;
    if (in_set_d && !entering && !inc_p) begin
      if (blink_cnt_q == BW'(BLINK_CYC - 1)) begin
        phase_d = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        phase_d     = phase_q;
      end
    end

    load_d      = (state_d == COMMIT);
    run_en_d    = (state_d == RUN);
    blank_hr_d  = (state_d == SET_HR) && phase_d;
    blank_min_d = (state_d == SET_MIN) && phase_d;
  end

`ifdef TIMEOUT_EN
  // Idle counter: restarts on any press, on set-state entry and outside set states.
  always_comb begin
    idle_d = '0;
    if (in_set_d && !entering && !mode_p && !inc_p) begin
      idle_d = idle_q + TW'(1);
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`endif

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      press_q     <= '0;
      // NOTE: the two debounce counters are a tiny register array, so they are reset explicitly.
      for (int k = 0; k < 2; k++) db_cnt_q[k] <= '0;
      state_q     <= RUN;
      set_hr_q    <= '0;
      set_min_q   <= '0;
      load_q      <= 1'b0;
      run_en_q    <= 1'b1;
      blank_hr_q  <= 1'b0;
      blank_min_q <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_q        <= db_d;
      press_q     <= press_d;
      for (int k = 0; k < 2; k++) db_cnt_q[k] <= db_cnt_d[k];
      state_q     <= state_d;
      set_hr_q    <= set_hr_d;
      set_min_q   <= set_min_d;
      load_q      <= load_d;
      run_en_q    <= run_en_d;
      blank_hr_q  <= blank_hr_d;
      blank_min_q <= blank_min_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign set_hr    = set_hr_q;
  assign set_min   = set_min_q;
  assign load      = load_q;
  assign run_en    = run_en_q;
  assign blank_hr  = blank_hr_q;
  assign blank_min = blank_min_q;
  assign mode      = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with DEBOUNCE_CYC=4, BLINK_CYC=8,
// TIMEOUT_CYC=100. A clean button edge applied at a falling clock edge
// updates the FSM outputs just after the 7th following rising edge.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] cur_hr = 5'd0;
  logic [5:0] cur_min = 6'd0;
  logic [4:0] set_hr;
  logic [5:0] set_min;
  logic       load;
  logic       run_en;
  logic       blank_hr;
  logic       blank_min;
  logic [1:0] mode;

  int n_checks = 0;
  int n_fail   = 0;
  int n_loads  = 0;

  time_set_ctrl #(
    .DEBOUNCE_CYC(4),
    .BLINK_CYC   (8),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .cur_hr   (cur_hr),
    .cur_min  (cur_min),
    .set_hr   (set_hr),
    .set_min  (set_min),
    .load     (load),
    .run_en   (run_en),
    .blank_hr (blank_hr),
    .blank_min(blank_min),
    .mode     (mode)
  );

  always #5 clk = ~clk;

  // Count load pulses seen on rising edges outside reset.
  always @(posedge clk) begin
    if (!rst && load) n_loads++;
  end

  typedef struct {
    logic       m;
    logic       i;
    logic [1:0] exp_mode;
    logic [4:0] exp_hr;
    logic [5:0] exp_min;
    logic       exp_run;
    logic       exp_load;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(input logic m, input logic i, input logic [1:0] md,
                              input logic [4:0] hr, input logic [5:0] mn,
                              input logic rn, input logic ld);
    vec_t v;
    v.m = m; v.i = i; v.exp_mode = md; v.exp_hr = hr; v.exp_min = mn;
    v.exp_run = rn; v.exp_load = ld;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic hold_btns);
    @(negedge clk);
    rst = 1'b1; btn_mode = hold_btns; btn_inc = hold_btns;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mode", mode, 0);
    check("rst_run_en", run_en, 1);
    check("rst_load", load, 0);
    check("rst_hr", set_hr, 0);
    check("rst_min", set_min, 0);
    check("rst_blank", {blank_hr, blank_min}, 0);
    @(negedge clk);
    rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  // Raise buttons at a falling edge; return just after the edge the FSM reacts on.
  task automatic press_hold(input logic m, input logic i);
    @(negedge clk);
    btn_mode = m; btn_inc = i;
    repeat (7) @(posedge clk);
    #1;
  endtask

  task automatic release_btns();
    btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 1, 13, 45, 0, 0);
    vecs[1]  = mk(0, 1, 1, 14, 45, 0, 0);
    vecs[2]  = mk(0, 1, 1, 15, 45, 0, 0);
    vecs[3]  = mk(1, 0, 2, 15, 45, 0, 0);
    vecs[4]  = mk(0, 1, 2, 15, 46, 0, 0);
    vecs[5]  = mk(0, 1, 2, 15, 47, 0, 0);
    vecs[6]  = mk(0, 1, 2, 15, 48, 0, 0);
    vecs[7]  = mk(0, 1, 2, 15, 49, 0, 0);
    vecs[8]  = mk(0, 1, 2, 15, 50, 0, 0);
    vecs[9]  = mk(0, 1, 2, 15, 51, 0, 0);
    vecs[10] = mk(0, 1, 2, 15, 52, 0, 0);
    vecs[11] = mk(0, 1, 2, 15, 53, 0, 0);
    vecs[12] = mk(0, 1, 2, 15, 54, 0, 0);
    vecs[13] = mk(0, 1, 2, 15, 55, 0, 0);
    vecs[14] = mk(0, 1, 2, 15, 56, 0, 0);
    vecs[15] = mk(0, 1, 2, 15, 57, 0, 0);
    vecs[16] = mk(0, 1, 2, 15, 58, 0, 0);
    vecs[17] = mk(0, 1, 2, 15, 59, 0, 0);
    vecs[18] = mk(0, 1, 2, 15, 0, 0, 0);
    vecs[19] = mk(1, 0, 3, 15, 0, 0, 1);

    // 1. Reset with buttons held.
    do_reset(1'b1);

    // 2. A 3-cycle glitch is rejected; a held press is accepted after 7 cycles.
    @(negedge clk);
    btn_mode = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    btn_mode = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      check("glitch_mode", mode, 0);
    end
    @(negedge clk);
    btn_mode = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("hold_mode_c6", mode, 0);
    @(posedge clk);
    #1;
    check("hold_mode_c7", mode, 1);
    check("hold_run_en", run_en, 0);
    repeat (3) @(posedge clk);
    #1;
    release_btns();
    check("release_no_pulse", mode, 1);

    // Reset mid-session abandons the edit without a load.
    do_reset(1'b0);
    check("midreset_loads", n_loads, 0);

    // 3. Full edit session from 13:45 driven from the vector table.
    cur_hr = 5'd13; cur_min = 6'd45;
    for (int v = 0; v < 20; v++) begin
      press_hold(vecs[v].m, vecs[v].i);
      check($sformatf("v%0d_mode", v), mode, vecs[v].exp_mode);
      check($sformatf("v%0d_hr", v), set_hr, vecs[v].exp_hr);
      check($sformatf("v%0d_min", v), set_min, vecs[v].exp_min);
      check($sformatf("v%0d_run_en", v), run_en, vecs[v].exp_run);
      check($sformatf("v%0d_load", v), load, vecs[v].exp_load);
      if (vecs[v].exp_mode == 2'd3) begin
        @(posedge clk);
        #1;
        check("post_commit_mode", mode, 0);
        check("post_commit_run_en", run_en, 1);
        check("post_commit_load", load, 0);
      end
      release_btns();
    end
    check("t3_load_count", n_loads, 1);

    // 4. 23 wraps to 0, then blank_hr blinks with an 8-cycle phase.
    cur_hr = 5'd23; cur_min = 6'd10;
    press_hold(1'b1, 1'b0);
    check("t4_enter_hr", set_hr, 23);
    release_btns();
    press_hold(1'b0, 1'b1);
    check("t4_wrap_hr", set_hr, 0);
    check("t4_blank_after_inc", blank_hr, 0);
    btn_inc = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("t4_blank_hr_%0d", k), blank_hr, (k >= 8 && k < 16) ? 1 : 0);
      check($sformatf("t4_blank_min_%0d", k), blank_min, 0);
    end
    check("t4_mode", mode, 1);

    // 5. Move to SET_MIN, then mode and inc together: mode wins.
    press_hold(1'b1, 1'b0);
    check("t5_set_min_mode", mode, 2);
    check("t5_min", set_min, 10);
    release_btns();
    press_hold(1'b1, 1'b1);
    check("t5_commit_mode", mode, 3);
    check("t5_commit_load", load, 1);
    check("t5_min_unchanged", set_min, 10);
    check("t5_hr", set_hr, 0);
    @(posedge clk);
    #1;
    check("t5_back_run", mode, 0);
    check("t5_run_en", run_en, 1);
    release_btns();
    check("t5_load_count", n_loads, 2);

    // 6. Idle session: abandoned after 100 cycles only with TIMEOUT_EN.
    cur_hr = 5'd5; cur_min = 6'd30;
    press_hold(1'b1, 1'b0);
    release_btns();
    press_hold(1'b0, 1'b1);
    check("t6_inc_hr", set_hr, 6);
    btn_inc = 1'b0;
`ifdef TIMEOUT_EN
    repeat (99) @(posedge clk);
    #1;
    check("t6_before_timeout", mode, 1);
    @(posedge clk);
    #1;
    check("t6_timeout_mode", mode, 0);
    check("t6_timeout_run_en", run_en, 1);
    check("t6_timeout_load", load, 0);
`else
    repeat (130) @(posedge clk);
    #1;
    check("t6_persist_mode", mode, 1);
    check("t6_persist_run_en", run_en, 0);
`endif
    check("t6_load_count", n_loads, 2);

    // Final reset abandons whatever session is left.
    do_reset(1'b0);
    check("final_load_count", n_loads, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
